// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS main controller FSM with memory wait timeout
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               aluZero,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic               illegalOp,
    output logic               busErr,
    output logic [STATE_W-1:0] stateOut
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Counter only needs to reach WAIT_LIMIT-1; the limit cycle itself is decided combinationally.
    localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    typedef struct packed {
        logic       pcwrite;
        logic       pcwrite_cond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       fetch;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctl_t;

    state_t           state;
    state_t           state_nxt;
    ctl_t             ctl;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_wait;
    logic             timeout;
    logic             set_ill;
    logic             illegal_q;
    logic             buserr_q;

    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.fetch   = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca      = 1'b1;
                c.aluop        = 2'b11;
                c.pcwrite_cond = 1'b1;
                c.pcsource     = 2'b01;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB: c.regwrite = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !memReady;
    assign timeout  = (WAIT_LIMIT > 0) && mem_wait && (wait_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        set_ill   = 1'b0;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  if (memReady) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default: begin
                        state_nxt = S_ERROR;
                        set_ill   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (memReady) state_nxt = S_MEMWB;
            S_MEMWR:  if (memReady) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_nxt = S_FETCH;
            S_ERROR:  state_nxt = S_ERROR;
            default:  state_nxt = S_ERROR;
        endcase
        if (timeout) state_nxt = S_ERROR;
    end

    // Moore controls are registered from the next state so they are valid in the state's first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RESET;
            ctl       <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctl       <= decode_ctl(state_nxt);
            wait_cnt  <= (mem_wait && !timeout) ? wait_cnt + CNT_W'(1) : '0;
            illegal_q <= illegal_q | set_ill;
            buserr_q  <= buserr_q | timeout;
        end
    end

    // Instruction fetch commits IR and PC only in the cycle memory returns data.
    assign irWrite     = ctl.fetch & memReady;
    assign pcWrite     = ctl.pcwrite | (ctl.fetch & memReady);
    assign pcWriteCond = ctl.pcwrite_cond;
    assign iorD        = ctl.iord;
    assign memRead     = ctl.memread;
    assign memWrite    = ctl.memwrite;
    assign memToReg    = ctl.memtoreg;
    assign regDst      = ctl.regdst;
    assign regWrite    = ctl.regwrite;
    assign aluSrcA     = ctl.alusrca;
    assign aluSrcB     = ctl.alusrcb;
    assign aluOp       = ctl.aluop;
    assign pcSource    = ctl.pcsource;
    assign illegalOp   = illegal_q;
    assign busErr      = buserr_q;
    assign stateOut    = STATE_W'(state);

    // The branch decision (pcWriteCond & aluZero) is made in the datapath's PC-enable gate.
    logic unused_alu_zero;
    assign unused_alu_zero = aluZero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed table-driven bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // pw pwc iord mr mw irw m2r rd rw asa asb aop pcs ill be
    localparam logic [17:0] C_ZERO  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_FRDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_FWAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_MADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_MRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_0;
    localparam logic [17:0] C_MWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_EXEC  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_AWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_0;
    localparam logic [17:0] C_BR    = 18'b0_1_0_0_0_0_0_0_0_1_00_11_01_0_0;
    localparam logic [17:0] C_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_0;
    localparam logic [17:0] C_AIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_AIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_0;
    localparam logic [17:0] C_EILL  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] C_EBUS  = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic       aluZero = 1'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp, busErr;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] stateOut;
    logic [17:0] act_ctl;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .aluZero(aluZero), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp), .busErr(busErr), .stateOut(stateOut)
    );

    always #5 clk = ~clk;

    assign act_ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst,
                      regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp, busErr};

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [17:0] c);
        vec_t v;
        v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.ctl = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Apply inputs, compare on the falling edge, then advance past the next rising edge.
    task automatic cyc(input string name, input logic r, input logic [5:0] op, input logic z,
                       input logic rdy, input logic [3:0] st, input logic [17:0] c);
        rst_n = r; opcode = op; aluZero = z; memReady = rdy;
        @(negedge clk);
        chk({name, ".state"}, {14'd0, stateOut}, {14'd0, st});
        chk({name, ".ctl"}, act_ctl, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) add(1'b0, OP_ADDI, 1'b0, 1'b1, 4'd0, C_ZERO);
        add(1'b1, OP_ADDI, 1'b0, 1'b1, 4'd0,  C_ZERO);
        add(1'b1, OP_ADDI, 1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_ADDI, 1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_ADDI, 1'b0, 1'b1, 4'd11, C_AIEX);
        add(1'b1, OP_ADDI, 1'b0, 1'b1, 4'd12, C_AIWB);
        add(1'b1, OP_LW,   1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_LW,   1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_LW,   1'b0, 1'b1, 4'd3,  C_MADR);
        for (int i = 0; i < 3; i++) add(1'b1, OP_LW, 1'b0, 1'b0, 4'd4, C_MRD);
        add(1'b1, OP_LW,   1'b0, 1'b1, 4'd4,  C_MRD);
        add(1'b1, OP_LW,   1'b0, 1'b1, 4'd5,  C_MWB);
        add(1'b1, OP_SW,   1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_SW,   1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_SW,   1'b0, 1'b1, 4'd3,  C_MADR);
        add(1'b1, OP_SW,   1'b0, 1'b0, 4'd6,  C_MWR);
        add(1'b1, OP_SW,   1'b0, 1'b1, 4'd6,  C_MWR);
        add(1'b1, OP_R,    1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_R,    1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_R,    1'b0, 1'b1, 4'd7,  C_EXEC);
        add(1'b1, OP_R,    1'b0, 1'b1, 4'd8,  C_AWB);
        add(1'b1, OP_BEQ,  1'b1, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_BEQ,  1'b1, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_BEQ,  1'b1, 1'b1, 4'd9,  C_BR);
        add(1'b1, OP_BEQ,  1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_BEQ,  1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_BEQ,  1'b0, 1'b1, 4'd9,  C_BR);
        add(1'b1, OP_J,    1'b0, 1'b0, 4'd1,  C_FWAIT);
        add(1'b1, OP_J,    1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_J,    1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_J,    1'b0, 1'b1, 4'd10, C_JMP);
        add(1'b1, OP_BAD,  1'b0, 1'b1, 4'd1,  C_FRDY);
        add(1'b1, OP_BAD,  1'b0, 1'b1, 4'd2,  C_DEC);
        add(1'b1, OP_BAD,  1'b0, 1'b1, 4'd15, C_EILL);

        foreach (tbl[i]) begin
            cyc($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].op, tbl[i].zero, tbl[i].rdy,
                tbl[i].st, tbl[i].ctl);
        end

        for (int i = 0; i < 20; i++) cyc("err_hold", 1'b1, OP_R, 1'b0, 1'b1, 4'd15, C_EILL);

        // Asynchronous reset clears the sticky flag without waiting for a clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_clr", {act_ctl, stateOut}, {C_ZERO, 4'd0});
        @(posedge clk);
        #1;

        // Bus error: FETCH stalls four cycles, then ERROR.
        cyc("be_rel", 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd0, C_ZERO);
        for (int i = 0; i < 4; i++) cyc("be_stall", 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd1, C_FWAIT);
        cyc("be_err", 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd15, C_EBUS);
        cyc("be_hold", 1'b1, OP_ADDI, 1'b0, 1'b1, 4'd15, C_EBUS);

        // memReady on the limit cycle completes normally.
        cyc("lim_rst", 1'b0, OP_ADDI, 1'b0, 1'b0, 4'd0, C_ZERO);
        cyc("lim_rel", 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd0, C_ZERO);
        for (int i = 0; i < 3; i++) cyc("lim_stall", 1'b1, OP_ADDI, 1'b0, 1'b0, 4'd1, C_FWAIT);
        cyc("lim_rdy", 1'b1, OP_ADDI, 1'b0, 1'b1, 4'd1, C_FRDY);
        cyc("lim_dec", 1'b1, OP_ADDI, 1'b0, 1'b1, 4'd2, C_DEC);

        // Reset during a stalled store must drop memWrite immediately.
        cyc("ab_rst", 1'b0, OP_SW, 1'b0, 1'b1, 4'd0, C_ZERO);
        cyc("ab_rel", 1'b1, OP_SW, 1'b0, 1'b1, 4'd0, C_ZERO);
        cyc("ab_f",   1'b1, OP_SW, 1'b0, 1'b1, 4'd1, C_FRDY);
        cyc("ab_d",   1'b1, OP_SW, 1'b0, 1'b1, 4'd2, C_DEC);
        cyc("ab_a",   1'b1, OP_SW, 1'b0, 1'b1, 4'd3, C_MADR);
        memReady = 1'b0;
        @(negedge clk);
        chk("ab_mwr", {act_ctl, stateOut}, {C_MWR, 4'd6});
        #1 rst_n = 1'b0;
        #1;
        chk("ab_abort", {act_ctl, stateOut}, {C_ZERO, 4'd0});
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
